// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one registered FIFO write port among NREQ producers,
// with credit-based overflow protection. Optional grant statistics: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              gnt,
  input  logic                         fifo_read,
  input  logic                         fifo_empty,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [WIDTH-1:0]             fifo_data_in,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         overflow_err
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]           gnt_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt_nxt;
  logic            found;
  logic            issue;
  logic            pop;
  int unsigned     idx;

  // The requester granted this cycle is masked so its stale word is never taken twice.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
    issue          = found && (credits != '0);
    pop            = fifo_read && !fifo_empty;
    gnt_nxt        = '0;
    gnt_nxt[winner] = 1'b1;
    ptr_nxt        = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      gnt          <= '0;
      fifo_write   <= 1'b0;
      fifo_data_in <= '0;
      credits      <= CW'(DEPTH);
      rr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      fifo_write <= issue;
      gnt        <= issue ? gnt_nxt : '0;
      if (issue) begin
        fifo_data_in <= req_data[winner*WIDTH +: WIDTH];
        rr_ptr       <= ptr_nxt;
      end
      case ({issue, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (credits != CW'(DEPTH)) credits <= credits + CW'(1);
        default: ;
      endcase
      if (fifo_write && fifo_full) overflow_err <= 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      gnt_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (issue && winner == PW'(i) && gnt_count[i*16 +: 16] != 16'hFFFF)
          gnt_count[i*16 +: 16] <= gnt_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a queue-based reference model predicts every
// cycle's outputs, and a monitor compares them one time unit after each rising edge.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst_;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         gnt;
  logic                    fifo_read, fifo_empty, fifo_full;
  logic                    fifo_write;
  logic [WIDTH-1:0]        fifo_data_in;
  logic [CW-1:0]           credits;
  logic                    overflow_err;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]      gnt_count;
  int                      m_cnt[NREQ];
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_read(fifo_read), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_data_in(fifo_data_in), .credits(credits),
    .overflow_err(overflow_err)
`ifdef FIFO_WR_ARB_STATS_EN
    , .gnt_count(gnt_count)
`endif
  );

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic             wr;
    logic [WIDTH-1:0] data;
    int               cred;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [NREQ-1:0]  m_gnt;
  logic             m_wr;
  logic [WIDTH-1:0] m_data;
  logic             m_ovf;
  int               m_cred, m_ptr, fcount;
  bit               force_empty, force_full;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = '0; m_wr = 1'b0; m_data = '0; m_ovf = 1'b0;
    m_cred = DEPTH; m_ptr = 0; fcount = 0;
`ifdef FIFO_WR_ARB_STATS_EN
    foreach (m_cnt[i]) m_cnt[i] = 0;
`endif
  endtask

  // Reference: pick the first requester at or after the pointer that is requesting and
  // was not granted last cycle; account a credit per issue and per real pop.
  task automatic model_step();
    bit pop, issue;
    int w;
    logic [NREQ-1:0] elig;
    pop = fifo_read && !fifo_empty;
    if (m_wr) fcount++;
    if (pop) fcount--;
    if (m_wr && fifo_full) m_ovf = 1'b1;
    elig = req & ~m_gnt;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    issue = (w >= 0) && (m_cred > 0);
    m_gnt = '0;
    m_wr  = issue;
    if (issue) begin
      m_gnt[w] = 1'b1;
      m_data   = req_data[w*WIDTH +: WIDTH];
      m_ptr    = (w + 1) % NREQ;
`ifdef FIFO_WR_ARB_STATS_EN
      if (m_cnt[w] < 65535) m_cnt[w]++;
`endif
    end
    if (issue && !pop) m_cred--;
    else if (pop && !issue && m_cred < DEPTH) m_cred++;
    sb.push_back('{m_gnt, m_wr, m_data, m_cred, m_ovf});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_ && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (gnt !== e.gnt || fifo_write !== e.wr || fifo_data_in !== e.data ||
          int'(credits) != e.cred || overflow_err !== e.ovf) begin
        miscompares++;
        $display("FAIL cycle@%0t: got gnt=%b wr=%b data=%h cred=%0d ovf=%b expected gnt=%b wr=%b data=%h cred=%0d ovf=%b",
                 $time, gnt, fifo_write, fifo_data_in, credits, overflow_err,
                 e.gnt, e.wr, e.data, e.cred, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    fifo_empty = force_empty || (fcount == 0);
    fifo_full  = force_full || (fcount == DEPTH);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    req = '0; fifo_read = 1'b0; force_empty = 1'b0; force_full = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    fifo_empty = 1'b1; fifo_full = 1'b0;
    rst_ = 1'b1;
  endtask

  // Granted requesters present a fresh word while keeping req high.
  task automatic refresh_granted();
    for (int i = 0; i < NREQ; i++)
      if (m_gnt[i]) req_data[i*WIDTH +: WIDTH] = 16'($urandom());
  endtask

  task automatic drive_random(int rdpct);
    for (int i = 0; i < NREQ; i++) begin
      if (m_gnt[i]) begin
        if ($urandom() % 2 == 0) req[i] = 1'b0;
        else req_data[i*WIDTH +: WIDTH] = 16'($urandom());
      end else if (req[i]) begin
        if ($urandom() % 16 == 0) req[i] = 1'b0;
      end else if ($urandom() % 3 == 0) begin
        req[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = 16'($urandom());
      end
    end
    fifo_read = ($urandom() % 100) < rdpct;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, nwr;
    bit hit;
    int pct[4] = '{20, 50, 80, 100};
    req_data = '0;
    rst_ = 1'b0;
    do_reset();
    rst_ = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_wr", 32'(fifo_write), 0);
    check("rst_data", 32'(fifo_data_in), 0);
    check("rst_credits", 32'(credits), DEPTH);
    check("rst_ovf", 32'(overflow_err), 0);
    @(negedge clk);
    rst_ = 1'b1;

    // Single requester
    req = 4'b0001;
    req_data[15:0] = 16'hA5A5;
    tick();
    check("single_gnt", 32'(gnt), 1);
    check("single_wr", 32'(fifo_write), 1);
    check("single_data", 32'(fifo_data_in), 32'hA5A5);
    check("single_credits", 32'(credits), 15);
    g = 0;
    repeat (6) begin
      refresh_granted();
      tick();
      if (gnt[0]) g++;
    end
    check("single_every_2nd", 32'(g), 3);

    // Round-robin, then credit stall
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 16'($urandom());
    nwr = 0;
    for (int k = 0; k < 20; k++) begin
      refresh_granted();
      tick();
      if (fifo_write) nwr++;
      if (k < 8) check("rr_order", 32'(gnt), 32'(1) << (k % 4));
    end
    check("stall_writes", 32'(nwr), 16);
    check("stall_credits", 32'(credits), 0);
    check("stall_gnt", 32'(gnt), 0);
    fifo_read = 1'b1;
    tick();
    fifo_read = 1'b0;
    check("pop_credit", 32'(credits), 1);
    tick();
    check("post_pop_gnt", 32'(gnt), 1);
    check("post_pop_credits", 32'(credits), 0);
    check("stall_ovf", 32'(overflow_err), 0);

    // Simultaneous issue and pop at credits = 5
    req = '0;
    fifo_read = 1'b1;
    for (int k = 0; k < 40 && m_cred < 5; k++) tick();
    req = 4'b1111;
    refresh_granted();
    tick();
    check("issue_pop_credits", 32'(credits), 5);
    check("issue_pop_wr", 32'(fifo_write), 1);
    req = '0;
    fifo_read = 1'b0;

    // Read while empty returns no credit
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    force_empty = 1'b1;
    fifo_empty = 1'b1;
    fifo_read = 1'b1;
    tick();
    check("read_empty_credits", 32'(credits), 15);
    force_empty = 1'b0;
    fifo_read = 1'b0;
    tick();

    // Randomized traffic
    do_reset();
    foreach (pct[p]) repeat (500) begin
      drive_random(pct[p]);
      tick();
    end

    // Sticky overflow flag
    req = 4'b1111;
    fifo_read = 1'b1;
    force_full = 1'b1;
    fifo_full = 1'b1;
    repeat (3) begin
      refresh_granted();
      tick();
    end
    check("ovf_set", 32'(overflow_err), 1);
    force_full = 1'b0;
    req = '0;
    fifo_read = 1'b0;
    repeat (3) tick();
    check("ovf_sticky", 32'(overflow_err), 1);
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      check("gnt_count", 32'(gnt_count[i*16 +: 16]), 32'(m_cnt[i]));
`endif

    // Asynchronous reset mid-write
    do_reset();
    req = 4'b1111;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      refresh_granted();
      tick();
      hit = (m_cred == 3) && m_wr;
    end
    check("async_setup", 32'(hit), 1);
    #2;
    rst_ = 1'b0;
    model_reset();
    sb.delete();
    #1;
    check("async_gnt", 32'(gnt), 0);
    check("async_wr", 32'(fifo_write), 0);
    check("async_credits", 32'(credits), DEPTH);
    check("async_data", 32'(fifo_data_in), 0);
    @(negedge clk);
    fifo_empty = 1'b1;
    fifo_full = 1'b0;
    rst_ = 1'b1;
    tick();
    check("async_ptr_gnt", 32'(gnt), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
